// File: rtl/rgb_matrix_pkg.sv
// rtl/rgb_matrix_pkg.sv - shared types, widths and pixel helpers for the HUB75 BCM driver
package rgb_matrix_pkg;

    typedef enum logic [1:0] {
        PREFETCH = 2'd0,
        SHIFT    = 2'd1,
        LATCH    = 2'd2,
        DISPLAY  = 2'd3
    } scan_state_e;

    // Widest pixel the channel extractor accepts (16 bits per channel)
    localparam int MAX_PIX_W = 48;

    // Channel selectors for chan_bit; pixel layout is {R,G,B}
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // Bits needed to index 0..n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bus address width; one spare code above the pixel range so out-of-range
    // accesses are representable even when the pixel count is a power of two
    function automatic int addr_w(input int npix);
        return $clog2(npix + 1);
    endfunction

    // Bit k of colour channel ch of a pixel with bpc bits per channel
    function automatic logic chan_bit(input logic [MAX_PIX_W-1:0] pix, input int bpc,
                                      input int ch, input int k);
        logic [MAX_PIX_W-1:0] sh;
        sh = pix >> ((2 - ch) * bpc + k);
        return sh[0];
    endfunction

endpackage

// File: rtl/rgb_matrix_bcm_driver_if.sv
// rtl/rgb_matrix_bcm_driver_if.sv - processor pixel port and page-swap handshake
interface rgb_matrix_bcm_driver_if #(
    parameter int AW  = 14,
    parameter int BPP = 12
);
    logic [AW-1:0]  addr;
    logic           wr_en;
    logic [BPP-1:0] wr_data;
    logic           rd_en;
    logic [BPP-1:0] rd_data;
    logic           rd_valid;
    logic           swap_req;
    logic           swap_ack;

    modport master (
        output addr, wr_en, wr_data, rd_en, swap_req,
        input  rd_data, rd_valid, swap_ack
    );

    modport slave (
        input  addr, wr_en, wr_data, rd_en, swap_req,
        output rd_data, rd_valid, swap_ack
    );
endinterface

// File: rtl/rgb_matrix_fb.sv
// rtl/rgb_matrix_fb.sv - one framebuffer bank with a bus port and a scan read port, read-first
module rgb_matrix_fb
    import rgb_matrix_pkg::*;
#(
    parameter int  DEPTH = 4096,
    parameter int  DW    = 12,
    localparam int IW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic [IW-1:0] bus_addr_i,
    input  logic          bus_we_i,
    input  logic [DW-1:0] bus_wdata_i,
    input  logic          bus_re_i,
    output logic [DW-1:0] bus_rdata_o,
    input  logic [IW-1:0] scan_addr_i,
    input  logic          scan_re_i,
    output logic [DW-1:0] scan_rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] bus_rdata_q;
    logic [DW-1:0] scan_rdata_q;

    // Bus port: write and read share the edge; the read sees the pre-write word
    always_ff @(posedge clk) begin
        if (bus_we_i) begin
            mem_q[bus_addr_i] <= bus_wdata_i;
        end
        if (bus_re_i) begin
            bus_rdata_q <= mem_q[bus_addr_i];
        end
    end

    // Scan port: never stalls the bus, and a colliding write is seen only afterwards
    always_ff @(posedge clk) begin
        if (scan_re_i) begin
            scan_rdata_q <= mem_q[scan_addr_i];
        end
    end

    assign bus_rdata_o  = bus_rdata_q;
    assign scan_rdata_o = scan_rdata_q;

endmodule

// File: rtl/rgb_matrix_bcm_driver.sv
// rtl/rgb_matrix_bcm_driver.sv - HUB75 BCM scan driver top; DOUBLE_BUFFER_EN adds a second frame page
module rgb_matrix_bcm_driver
    import rgb_matrix_pkg::*;
#(
    parameter int  WIDTH   = 128,
    parameter int  HEIGHT  = 64,
    parameter int  BPC     = 4,
    parameter int  CHAINED = 1,
    parameter int  BASE_ON = 32,
    localparam int SROWS   = HEIGHT / 2,
    localparam int RW      = cnt_w(SROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    rgb_matrix_bcm_driver_if.slave bus,
    output logic                   sclk_o,
    output logic                   lat_o,
    output logic                   oe_n_o,
    output logic [RW-1:0]          row_addr_o,
    output logic                   r0_o,
    output logic                   g0_o,
    output logic                   b0_o,
    output logic                   r1_o,
    output logic                   g1_o,
    output logic                   b1_o,
    output logic                   frame_done_o
);

    localparam int COLS       = CHAINED * WIDTH;
    localparam int BPP        = 3 * BPC;
    localparam int NPIX       = COLS * HEIGHT;
    localparam int AW         = addr_w(NPIX);
    localparam int BANK_WORDS = SROWS * COLS;
`ifdef DOUBLE_BUFFER_EN
    localparam int PAGES      = 2;
`else
    localparam int PAGES      = 1;
`endif
    localparam int FB_DEPTH   = PAGES * BANK_WORDS;
    localparam int FIW        = cnt_w(FB_DEPTH);
    localparam int CW         = cnt_w(COLS);
    localparam int PW         = cnt_w(BPC);
    localparam int DCW        = cnt_w(BASE_ON << (BPC - 1));

    scan_state_e    state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic           phase_q, phase_d;
    logic [PW-1:0]  plane_q, plane_d;
    logic [RW-1:0]  row_q, row_d;
    logic [DCW-1:0] disp_q, disp_d;
    logic [RW-1:0]  row_addr_q, row_addr_d;

    logic           scan_re;
    logic [CW-1:0]  scan_col;
    logic [FIW-1:0] scan_idx;
    logic [BPP-1:0] top_scan, bot_scan;
    logic           disp_last, plane_last, row_last;

    logic           bus_in_range, bus_bottom;
    logic [AW-1:0]  bus_word;
    logic [FIW-1:0] bus_idx;
    logic           top_we, bot_we, top_re, bot_re;
    logic [BPP-1:0] top_bus_rdata, bot_bus_rdata;
    logic           rd_valid_q, rd_bot_q, rd_hit_q;
    logic           bus_page, scan_page;

    // Bus decode: rows 0..SROWS-1 live in the top bank, the rest in the bottom bank
    assign bus_in_range = bus.addr < AW'(NPIX);
    assign bus_bottom   = bus.addr >= AW'(BANK_WORDS);
    assign bus_word     = bus_bottom ? bus.addr - AW'(BANK_WORDS) : bus.addr;
    assign bus_idx      = FIW'(32'(bus_page) * BANK_WORDS + 32'(bus_word));
    assign top_we       = bus.wr_en & bus_in_range & ~bus_bottom;
    assign bot_we       = bus.wr_en & bus_in_range &  bus_bottom;
    assign top_re       = bus.rd_en & bus_in_range & ~bus_bottom;
    assign bot_re       = bus.rd_en & bus_in_range &  bus_bottom;

    assign scan_idx = FIW'(32'(scan_page) * BANK_WORDS + 32'(row_q) * COLS + 32'(scan_col));

    rgb_matrix_fb #(.DEPTH(FB_DEPTH), .DW(BPP)) u_fb_top (
        .clk          (clk),
        .bus_addr_i   (bus_idx),
        .bus_we_i     (top_we),
        .bus_wdata_i  (bus.wr_data),
        .bus_re_i     (top_re),
        .bus_rdata_o  (top_bus_rdata),
        .scan_addr_i  (scan_idx),
        .scan_re_i    (scan_re),
        .scan_rdata_o (top_scan)
    );

    rgb_matrix_fb #(.DEPTH(FB_DEPTH), .DW(BPP)) u_fb_bot (
        .clk          (clk),
        .bus_addr_i   (bus_idx),
        .bus_we_i     (bot_we),
        .bus_wdata_i  (bus.wr_data),
        .bus_re_i     (bot_re),
        .bus_rdata_o  (bot_bus_rdata),
        .scan_addr_i  (scan_idx),
        .scan_re_i    (scan_re),
        .scan_rdata_o (bot_scan)
    );

    // Remember which bank a read addressed so the returned word can be steered one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_bot_q   <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            rd_bot_q   <= bus_bottom;
            rd_hit_q   <= bus_in_range;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = (rd_valid_q && rd_hit_q) ? (rd_bot_q ? bot_bus_rdata : top_bus_rdata)
                                                   : '0;

    assign disp_last  = disp_q == DCW'((32'(BASE_ON) << plane_q) - 32'd1);
    assign plane_last = plane_q == PW'(BPC - 1);
    assign row_last   = row_q == RW'(SROWS - 1);

    // Scan state register with its column, plane, row and on-time counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PREFETCH;
            col_q      <= '0;
            phase_q    <= 1'b0;
            plane_q    <= '0;
            row_q      <= '0;
            disp_q     <= '0;
            row_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            phase_q    <= phase_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            disp_q     <= disp_d;
            row_addr_q <= row_addr_d;
        end
    end

    // Next scan state; column reads are issued one cycle ahead of the column being shifted
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        phase_d    = phase_q;
        plane_d    = plane_q;
        row_d      = row_q;
        disp_d     = disp_q;
        row_addr_d = row_addr_q;
        scan_re    = 1'b0;
        scan_col   = '0;
        unique case (state_q)
            PREFETCH: begin
                scan_re = 1'b1;
                state_d = SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = LATCH;
                    end else begin
                        col_d    = col_q + 1'b1;
                        scan_re  = 1'b1;
                        scan_col = col_q + 1'b1;
                    end
                end
            end
            LATCH: begin
                row_addr_d = row_q;
                disp_d     = '0;
                state_d    = DISPLAY;
            end
            DISPLAY: begin
                if (disp_last) begin
                    state_d = PREFETCH;
                    if (plane_last) begin
                        plane_d = '0;
                        row_d   = row_last ? '0 : row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end else begin
                    disp_d = disp_q + 1'b1;
                end
            end
        endcase
    end

    // Panel pins decoded from the scan state; oe_n is high outside DISPLAY
    always_comb begin
        sclk_o       = 1'b0;
        lat_o        = 1'b0;
        oe_n_o       = 1'b1;
        r0_o         = 1'b0;
        g0_o         = 1'b0;
        b0_o         = 1'b0;
        r1_o         = 1'b0;
        g1_o         = 1'b0;
        b1_o         = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            PREFETCH: ;
            SHIFT: begin
                sclk_o = phase_q;
                r0_o   = chan_bit(MAX_PIX_W'(top_scan), BPC, CH_R, 32'(plane_q));
                g0_o   = chan_bit(MAX_PIX_W'(top_scan), BPC, CH_G, 32'(plane_q));
                b0_o   = chan_bit(MAX_PIX_W'(top_scan), BPC, CH_B, 32'(plane_q));
                r1_o   = chan_bit(MAX_PIX_W'(bot_scan), BPC, CH_R, 32'(plane_q));
                g1_o   = chan_bit(MAX_PIX_W'(bot_scan), BPC, CH_G, 32'(plane_q));
                b1_o   = chan_bit(MAX_PIX_W'(bot_scan), BPC, CH_B, 32'(plane_q));
            end
            LATCH: begin
                lat_o = 1'b1;
            end
            DISPLAY: begin
                oe_n_o       = 1'b0;
                frame_done_o = disp_last & plane_last & row_last;
            end
        endcase
    end

    assign row_addr_o = row_addr_q;

`ifdef DOUBLE_BUFFER_EN
    logic front_q, pending_q, swap_now;

    assign swap_now = frame_done_o & pending_q;

    // Sticky swap request; the front page flips as the last plane of the frame ends
    always_ff @(posedge clk) begin
        if (rst) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else if (swap_now) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
        end else if (bus.swap_req) begin
            pending_q <= 1'b1;
        end
    end

    assign bus.swap_ack = swap_now;
    assign scan_page    = front_q;
    assign bus_page     = ~front_q;
`else
    assign bus.swap_ack = 1'b0;
    assign scan_page    = 1'b0;
    assign bus_page     = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_matrix_bcm_driver.sv
// tb/tb_rgb_matrix_bcm_driver.sv - self-checking bench for rgb_matrix_bcm_driver
module tb_rgb_matrix_bcm_driver;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int BPC     = 2;
    localparam int CHAINED = 1;
    localparam int BASE_ON = 4;
    localparam int COLS    = WIDTH * CHAINED;
    localparam int SROWS   = HEIGHT / 2;
    localparam int NPIX    = COLS * HEIGHT;
    localparam int BPP     = 3 * BPC;
    localparam int AW      = 6;
    localparam int ROWP    = BPC * (2 * COLS + 2) + BASE_ON * ((1 << BPC) - 1);
    localparam int FRAME   = SROWS * ROWP;
`ifdef DOUBLE_BUFFER_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, lat, oe_n, row_addr;
    logic r0, g0, b0, r1, g1, b1, frame_done;

    rgb_matrix_bcm_driver_if #(.AW(AW), .BPP(BPP)) bus ();

    rgb_matrix_bcm_driver #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPC(BPC), .CHAINED(CHAINED), .BASE_ON(BASE_ON)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sclk_o       (sclk),
        .lat_o        (lat),
        .oe_n_o       (oe_n),
        .row_addr_o   (row_addr),
        .r0_o         (r0),
        .g0_o         (g0),
        .b0_o         (b0),
        .r1_o         (r1),
        .g1_o         (g1),
        .b1_o         (b1),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [BPP-1:0] pg [2][NPIX];
    int front = 0;

    function automatic int back_page();
        return (DB != 0) ? 1 - front : front;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int a, input logic [BPP-1:0] d);
        bus.addr    = AW'(a);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (a < NPIX) pg[back_page()][a] = d;
    endtask

    task automatic bus_read_chk(input string tag, input int a);
        logic [BPP-1:0] e;
        e = (a < NPIX) ? pg[back_page()][a] : '0;
        bus.addr  = AW'(a);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, bus.rd_valid, 1);
        chk(tag, bus.rd_data, e);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk(tag, frame_done, 1);
    endtask

    // Walks one whole frame from its first PREFETCH cycle, predicting pins from the page model
    task automatic check_frame(input bit coll);
        int lats, col, oe_cnt, sclks, plane, rowi;
        logic [BPP-1:0] old0, newpix, tp, bt, e;
        wait_frame_done("sync_frame_done");
        old0   = pg[front][0];
        newpix = BPP'($urandom);
        lats = 0; col = 0; oe_cnt = 0; sclks = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (coll && i == 0) begin
                bus.addr = '0; bus.wr_data = newpix; bus.wr_en = 1'b1;
            end
            if (coll && i == 1) begin
                bus.wr_en = 1'b0;
                pg[back_page()][0] = newpix;
            end
            plane = lats % BPC;
            rowi  = lats / BPC;
            if (sclk === 1'b1 && lats < BPC * SROWS) begin
                tp = (coll && lats == 0 && col == 0) ? old0 : pg[front][rowi * COLS + col];
                bt = pg[front][(rowi + SROWS) * COLS + col];
                e  = {tp[2*BPC+plane], tp[BPC+plane], tp[plane],
                      bt[2*BPC+plane], bt[BPC+plane], bt[plane]};
                chk("scan_bits", {r0, g0, b0, r1, g1, b1}, e);
                col++;
            end
            if (sclk === 1'b1) sclks++;
            if (lat === 1'b1) begin
                chk("cols_before_lat", col, COLS);
                if (lats > 0) chk("oe_low_len", oe_cnt, BASE_ON << ((lats - 1) % BPC));
                col = 0; oe_cnt = 0; lats++;
            end
            if (oe_n === 1'b0) begin
                oe_cnt++;
                chk("no_ghost", {sclk, lat}, 0);
                if (oe_cnt == 1) chk("row_addr", row_addr, (lats - 1) / BPC);
            end
            chk("frame_done", frame_done, i == FRAME - 1);
            if (i == FRAME - 1) chk("swap_ack_idle", bus.swap_ack, 0);
        end
        chk("oe_low_len_last", oe_cnt, BASE_ON << (BPC - 1));
        chk("lat_count", lats, BPC * SROWS);
        chk("sclk_count", sclks, BPC * SROWS * COLS);
    endtask

    task automatic swap_test();
        int acks, fds, n;
        wait_frame_done("swap_sync");
        repeat (30) @(negedge clk);
        bus.swap_req = 1'b1; @(negedge clk); bus.swap_req = 1'b0;
        repeat (5) @(negedge clk);
        bus.swap_req = 1'b1; @(negedge clk); bus.swap_req = 1'b0;
        acks = 0; fds = 0; n = 0;
        while (fds == 0 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            chk("swap_ack_vs_fd", bus.swap_ack, (DB != 0) ? frame_done : 1'b0);
            if (bus.swap_ack === 1'b1) acks++;
            if (frame_done === 1'b1) fds++;
        end
        chk("swap_seen_fd", fds, 1);
        chk("swap_ack_count", acks, DB);
        front = (DB != 0) ? 1 - front : front;
    endtask

    task automatic reset_release_chk(input string tag);
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_sclk_low"}, sclk, 0);
        @(posedge clk); #1;
        chk({tag, "_sclk_rise"}, sclk, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BPP-1:0] old, d;
        int n;
        bus.addr = '0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.swap_req = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_lat", lat, 0);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_colour", {r0, g0, b0, r1, g1, b1}, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_swap_ack", bus.swap_ack, 0);
        chk("rst_frame_done", frame_done, 0);
        reset_release_chk("first");

        // Bus write then read, latency and out-of-range
        bus_write(5, 6'b10_01_11);
        bus_read_chk("rd_addr5", 5);
        @(negedge clk);
        chk("rd_valid_pulse", bus.rd_valid, 0);
        bus_write(40, BPP'($urandom));
        bus_read_chk("rd_oor", 40);

        // Random fill and read-back
        for (int a = 0; a < NPIX; a++) bus_write(a, BPP'($urandom));
        repeat (6) bus_read_chk("rd_rand", $urandom_range(0, NPIX - 1));

        // Read-first on a simultaneous read and write
        old = pg[back_page()][7];
        d   = ~old;
        bus.addr = AW'(7); bus.wr_data = d; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        pg[back_page()][7] = d;
        chk("rd_first_old", bus.rd_data, old);
        bus_read_chk("rd_after_wr", 7);

        // Page swap (no effect in a single-page build)
        swap_test();

        // Second random fill plus directed mapping pixels, then scan checks
        for (int a = 0; a < NPIX; a++) bus_write(a, BPP'($urandom));
        bus_write(0, 6'b11_00_00);
        bus_write(2 * COLS, 6'b00_00_01);
        check_frame(1'b0);
        check_frame(1'b1);
        check_frame(1'b0);

        // Writes landing while the scan runs, then swap and recheck
        n = 0;
        repeat (40) begin
            bus_write($urandom_range(0, NPIX + 15), BPP'($urandom));
            n++;
        end
        swap_test();
        check_frame(1'b0);
        swap_test();

        // Reset mid-frame with a swap pending: page 0 comes back to the front, no ack
        wait_frame_done("rst_sync");
        repeat (20) @(negedge clk);
        bus.swap_req = 1'b1; @(negedge clk); bus.swap_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_oe_n", oe_n, 1);
        chk("midrst_lat", lat, 0);
        front = 0;
        reset_release_chk("midrst");
        wait_frame_done("midrst_fd");
        chk("midrst_no_ack", bus.swap_ack, 0);
        check_frame(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
